// File: rtl/module_status_sampler_if.sv
// Record stream between the status sampler and the CSV dump side.
interface module_status_sampler_if #(
  parameter int unsigned TS_W = 32
) ();
  logic              rec_valid;
  logic              rec_ready;
  logic [TS_W+9:0]   rec_data;

  modport master (output rec_valid, output rec_data, input rec_ready);
  modport slave  (input rec_valid, input rec_data, output rec_ready);
endinterface

// File: rtl/module_status_sampler.sv
// Samples submodule ap_ready/ap_done handshakes into timestamped records and
// appends per-module ready/busy summaries when the run finishes.
module module_status_sampler #(
  parameter int unsigned N_MOD      = 10,
  parameter int unsigned TS_W       = 32,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic                   enable,
  input  logic [N_MOD-1:0]       mod_start,
  input  logic [N_MOD-1:0]       mod_ready,
  input  logic [N_MOD-1:0]       mod_done,
  input  logic                   finish,
  module_status_sampler_if.master rec,
  output logic [TS_W-1:0]        drop_count,
  output logic                   done
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned RW = TS_W + 10;
  localparam logic [9:0]  SUM_LAST = 10'(2 * N_MOD);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_FLUSH, S_SUMMARY, S_DONE} state_e;

  state_e                 state_q, state_d;
  logic [TS_W-1:0]        ts_q, ts_d;
  logic [TS_W-1:0]        ready_cnt_q [N_MOD];
  logic [TS_W-1:0]        ready_cnt_d [N_MOD];
  logic [TS_W-1:0]        busy_cnt_q  [N_MOD];
  logic [TS_W-1:0]        busy_cnt_d  [N_MOD];
  logic [N_MOD-1:0]       lat_vld_q, lat_vld_d;
  logic [N_MOD-1:0]       lat_kind_q, lat_kind_d;
  logic [TS_W-1:0]        lat_ts_q [N_MOD];
  logic [TS_W-1:0]        lat_ts_d [N_MOD];
  logic [7:0]             rr_q, rr_d;
  logic [9:0]             sum_idx_q, sum_idx_d;
  logic [TS_W-1:0]        drop_q, drop_d;
  logic                   done_q, done_d;
  logic [RW-1:0]          mem_q [FIFO_DEPTH];
  logic [RW-1:0]          mem_d [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]            cnt_q, cnt_d;

  logic                   full, empty, pop, push;
  logic [RW-1:0]          push_data;
  logic                   gnt_vld, gnt_kind;
  logic [7:0]             gnt_idx;
  logic [TS_W-1:0]        gnt_ts;
  logic [7:0]             sum_mod;
  logic [TS_W-1:0]        sum_pay;

  assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign pop   = !empty && rec.rec_ready;

  // Round-robin: first valid latch at or above rr_q, then wrap to below it.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    gnt_kind = 1'b0;
    gnt_ts   = '0;
    if ((state_q == S_RUN || state_q == S_FLUSH) && !full) begin
      for (int unsigned j = 0; j < N_MOD; j++) begin
        if (!gnt_vld && 8'(j) >= rr_q && lat_vld_q[j]) begin
          gnt_vld  = 1'b1;
          gnt_idx  = 8'(j);
          gnt_kind = lat_kind_q[j];
          gnt_ts   = lat_ts_q[j];
        end
      end
      for (int unsigned j = 0; j < N_MOD; j++) begin
        if (!gnt_vld && 8'(j) < rr_q && lat_vld_q[j]) begin
          gnt_vld  = 1'b1;
          gnt_idx  = 8'(j);
          gnt_kind = lat_kind_q[j];
          gnt_ts   = lat_ts_q[j];
        end
      end
    end
  end

  always_comb begin
    sum_mod = sum_idx_q[8:1];
    sum_pay = '0;
    for (int unsigned j = 0; j < N_MOD; j++) begin
      if (8'(j) == sum_mod) begin
        sum_pay = sum_idx_q[0] ? busy_cnt_q[j] : ready_cnt_q[j];
      end
    end
    push      = 1'b0;
    push_data = '0;
    if (gnt_vld) begin
      push      = 1'b1;
      push_data = {1'b0, gnt_kind, gnt_idx, gnt_ts};
    end else if (state_q == S_SUMMARY && sum_idx_q != SUM_LAST && !full) begin
      push      = 1'b1;
      push_data = {1'b1, sum_idx_q[0], sum_mod, sum_pay};
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    int unsigned     drops;
    logic            wr_i;
    logic            free;
    logic [TS_W:0]   drop_sum;
    drops       = 0;
    wr_i        = 1'b0;
    free        = 1'b0;
    ready_cnt_d = ready_cnt_q;
    busy_cnt_d  = busy_cnt_q;
    lat_vld_d   = lat_vld_q;
    lat_kind_d  = lat_kind_q;
    lat_ts_d    = lat_ts_q;
    ts_d        = ts_q;
    rr_d        = rr_q;
    sum_idx_d   = sum_idx_q;
    state_d     = state_q;

    for (int unsigned i = 0; i < N_MOD; i++) begin
      wr_i = gnt_vld && (gnt_idx == 8'(i));
      free = !lat_vld_q[i] || wr_i;
      if (wr_i) lat_vld_d[i] = 1'b0;
      if (state_q == S_RUN) begin
        // READY wins the latch; a coincident DONE is always lost.
        if (mod_ready[i]) begin
          if (free) begin
            lat_vld_d[i]  = 1'b1;
            lat_kind_d[i] = 1'b0;
            lat_ts_d[i]   = ts_q;
          end else begin
            drops++;
          end
          if (mod_done[i]) drops++;
        end else if (mod_done[i]) begin
          if (free) begin
            lat_vld_d[i]  = 1'b1;
            lat_kind_d[i] = 1'b1;
            lat_ts_d[i]   = ts_q;
          end else begin
            drops++;
          end
        end
        if (mod_ready[i] && ready_cnt_q[i] != '1) ready_cnt_d[i] = ready_cnt_q[i] + TS_W'(1);
        if (mod_start[i] && busy_cnt_q[i] != '1)  busy_cnt_d[i]  = busy_cnt_q[i] + TS_W'(1);
      end
    end

    drop_sum = {1'b0, drop_q} + (TS_W+1)'(drops);
    drop_d   = drop_sum[TS_W] ? '1 : drop_sum[TS_W-1:0];

    if (gnt_vld) rr_d = (gnt_idx == 8'(N_MOD - 1)) ? '0 : gnt_idx + 8'd1;
    if (state_q == S_RUN) ts_d = ts_q + TS_W'(1);
    if (state_q == S_SUMMARY && push) sum_idx_d = sum_idx_q + 10'd1;

    case (state_q)
      S_IDLE:    if (enable) state_d = S_RUN;
      S_RUN:     if (finish) state_d = S_FLUSH;
      S_FLUSH:   if (lat_vld_q == '0) state_d = S_SUMMARY;
      // Looks at next-cycle FIFO occupancy so done follows the final pop directly.
      S_SUMMARY: if (sum_idx_d == SUM_LAST && cnt_d == '0) state_d = S_DONE;
      S_DONE:    state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= S_IDLE;
      ts_q        <= '0;
      ready_cnt_q <= '{default: '0};
      busy_cnt_q  <= '{default: '0};
      lat_vld_q   <= '0;
      lat_kind_q  <= '0;
      lat_ts_q    <= '{default: '0};
      rr_q        <= '0;
      sum_idx_q   <= '0;
      drop_q      <= '0;
      done_q      <= 1'b0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ts_q        <= ts_d;
      ready_cnt_q <= ready_cnt_d;
      busy_cnt_q  <= busy_cnt_d;
      lat_vld_q   <= lat_vld_d;
      lat_kind_q  <= lat_kind_d;
      lat_ts_q    <= lat_ts_d;
      rr_q        <= rr_d;
      sum_idx_q   <= sum_idx_d;
      drop_q      <= drop_d;
      done_q      <= done_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rec.rec_valid = !empty;
  assign rec.rec_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign drop_count    = drop_q;
  assign done          = done_q;

endmodule

// File: tb/tb_module_status_sampler.sv
// Directed bench for module_status_sampler with hand-computed records.
module tb_module_status_sampler;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        enable;
  logic        finish;
  logic [9:0]  mod_start, mod_ready, mod_done;
  logic [31:0] drop_count;
  logic        done;

  int          checks   = 0;
  int          failures = 0;
  int          ts_m     = 0;
  bit          run_m    = 1'b0;

  module_status_sampler_if #(.TS_W(32)) rec_if ();

  module_status_sampler #(
    .N_MOD      (10),
    .TS_W       (32),
    .FIFO_DEPTH (16)
  ) dut (
    .ap_clk     (ap_clk),
    .ap_rst_n   (ap_rst_n),
    .enable     (enable),
    .mod_start  (mod_start),
    .mod_ready  (mod_ready),
    .mod_done   (mod_done),
    .finish     (finish),
    .rec        (rec_if),
    .drop_count (drop_count),
    .done       (done)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [41:0] mk_rec(input logic [1:0] kind, input logic [7:0] id,
                                         input logic [31:0] ts);
    return {kind, id, ts};
  endfunction

  task automatic tick();
    @(posedge ap_clk);
    #1;
    if (run_m) ts_m++;
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    enable = 1'b0; finish = 1'b0;
    mod_start = '0; mod_ready = '0; mod_done = '0;
    rec_if.rec_ready = 1'b0;
    run_m = 1'b0; ts_m = 0;
    @(posedge ap_clk); @(posedge ap_clk); #2;
    ap_rst_n = 1'b1;
  endtask

  task automatic start_run();
    enable = 1'b1;
    tick();
    enable = 1'b0;
    run_m = 1'b1;
    ts_m = 0;
  endtask

  task automatic stop_run();
    finish = 1'b1;
    tick();
    finish = 1'b0;
    run_m = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [41:0] exp);
    int n;
    n = 0;
    while (!rec_if.rec_valid && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, {63'd0, rec_if.rec_valid}, 64'd1);
    if (rec_if.rec_valid) begin
      check(tag, {22'd0, rec_if.rec_data}, {22'd0, exp});
      rec_if.rec_ready = 1'b1;
      tick();
      rec_if.rec_ready = 1'b0;
    end
  endtask

  initial begin
    int ts_at;

    // Session A: reset values, single event latency, ready+done collision, DONE event
    do_reset();
    check("rst_valid", {63'd0, rec_if.rec_valid}, 64'd0);
    check("rst_data",  {22'd0, rec_if.rec_data}, 64'd0);
    check("rst_drop",  {32'd0, drop_count}, 64'd0);
    check("rst_done",  {63'd0, done}, 64'd0);

    start_run();
    repeat (5) tick();
    mod_ready[3] = 1'b1;
    tick();
    mod_ready = '0;
    check("t1_valid_early", {63'd0, rec_if.rec_valid}, 64'd0);
    tick();
    check("t1_valid", {63'd0, rec_if.rec_valid}, 64'd1);
    check("t1_data",  {22'd0, rec_if.rec_data}, {22'd0, mk_rec(2'd0, 8'd3, 32'd5)});
    check("t1_drop",  {32'd0, drop_count}, 64'd0);
    rec_if.rec_ready = 1'b1;
    tick();
    rec_if.rec_ready = 1'b0;
    check("t1_empty", {63'd0, rec_if.rec_valid}, 64'd0);

    ts_at = ts_m;
    mod_ready[1] = 1'b1; mod_done[1] = 1'b1;
    tick();
    mod_ready = '0; mod_done = '0;
    pop_expect("t4_rec", mk_rec(2'd0, 8'd1, 32'(ts_at)));
    check("t4_drop", {32'd0, drop_count}, 64'd1);
    repeat (4) tick();
    check("t4_no_done_rec", {63'd0, rec_if.rec_valid}, 64'd0);

    ts_at = ts_m;
    mod_done[6] = 1'b1;
    tick();
    mod_done = '0;
    pop_expect("t_done_rec", mk_rec(2'd1, 8'd6, 32'(ts_at)));

    // Session B: contention, busy counting, summary and done
    do_reset();
    start_run();
    repeat (7) tick();
    mod_ready = '1;
    tick();
    mod_ready = '0;
    for (int i = 0; i < 10; i++) pop_expect("t2_rec", mk_rec(2'd0, 8'(i), 32'd7));
    check("t2_drop", {32'd0, drop_count}, 64'd0);

    mod_start[4] = 1'b1;
    repeat (30) tick();
    mod_start = '0;
    while (ts_m < 99) tick();
    stop_run();
    for (int i = 0; i < 10; i++) begin
      pop_expect("t5_rdy", mk_rec(2'd2, 8'(i), 32'd1));
      if (i == 9) check("t5_done_pre", {63'd0, done}, 64'd0);
      pop_expect("t5_busy", mk_rec(2'd3, 8'(i), (i == 4) ? 32'd30 : 32'd0));
    end
    check("t5_done", {63'd0, done}, 64'd1);
    repeat (3) tick();
    check("t5_done_hold", {63'd0, done}, 64'd1);
    check("t5_empty", {63'd0, rec_if.rec_valid}, 64'd0);

    // Session C: backpressure overflow, then reset in the middle of SUMMARY
    do_reset();
    start_run();
    mod_ready[2] = 1'b1;
    repeat (40) tick();
    mod_ready = '0;
    check("t3_drop",  {32'd0, drop_count}, 64'd23);
    check("t3_valid", {63'd0, rec_if.rec_valid}, 64'd1);
    check("t3_head",  {22'd0, rec_if.rec_data}, {22'd0, mk_rec(2'd0, 8'd2, 32'd0)});
    stop_run();
    for (int k = 0; k < 17; k++) pop_expect("t3_rec", mk_rec(2'd0, 8'd2, 32'(k)));
    pop_expect("t3_sum0r", mk_rec(2'd2, 8'd0, 32'd0));
    pop_expect("t3_sum0b", mk_rec(2'd3, 8'd0, 32'd0));
    pop_expect("t3_sum1r", mk_rec(2'd2, 8'd1, 32'd0));
    pop_expect("t3_sum1b", mk_rec(2'd3, 8'd1, 32'd0));
    pop_expect("t3_sum2r", mk_rec(2'd2, 8'd2, 32'd40));

    ap_rst_n = 1'b0;
    #1;
    check("t6_valid", {63'd0, rec_if.rec_valid}, 64'd0);
    check("t6_data",  {22'd0, rec_if.rec_data}, 64'd0);
    check("t6_drop",  {32'd0, drop_count}, 64'd0);
    check("t6_done",  {63'd0, done}, 64'd0);
    #2;
    ap_rst_n = 1'b1;
    run_m = 1'b0;
    start_run();
    mod_ready[5] = 1'b1;
    tick();
    mod_ready = '0;
    pop_expect("t6_restart", mk_rec(2'd0, 8'd5, 32'd0));
    check("t6_drop_after", {32'd0, drop_count}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/module_status_sampler.md
# module_status_sampler

Synthesizable activity sampler that sits directly upstream of the CSV module-status dump. It watches the ap_start/ap_ready/ap_done handshakes of up to N_MOD decision-function submodules of the BDT top. It turns ready and done pulses into timestamped event records on a valid/ready stream. At finish it appends per-module summary records (ready count, busy cycles), so the dump side only serialises records and never probes hierarchy.

## Interface
- N_MOD, 10, number of monitored modules (1..256)
- TS_W, 32, timestamp and counter width
- FIFO_DEPTH, 16, record FIFO depth (power of 2, >=2)

Ports:
- ap_clk  in  1  single clock for the whole block
- ap_rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  arms sampling
- mod_start  in  N_MOD  ap_start of each monitored module
- mod_ready  in  N_MOD  ap_ready of each monitored module
- mod_done  in  N_MOD  ap_done of each monitored module
- finish  in  1  end of simulation/run request
- rec_valid  out  1  record available
- rec_ready  in  1  consumer accepts record
- rec_data  out  TS_W+10  {kind[1:0], mod_id[7:0], payload[TS_W-1:0]}
- drop_count  out  TS_W  events lost, saturating
- done  out  1  all records delivered

## Operation
- Record kinds: 0 = READY event, payload is the timestamp; 1 = DONE event, payload is the timestamp; 2 = SUMMARY ready count; 3 = SUMMARY busy cycles.
- States: IDLE, RUN, FLUSH, SUMMARY, DONE.
  - IDLE -> RUN when enable=1.
  - RUN -> FLUSH when finish=1.
  - FLUSH -> SUMMARY when all pending latches are empty.
  - SUMMARY -> DONE when the last summary record is written and the FIFO is empty.
  - DONE holds until reset. enable is ignored outside IDLE.
- Timestamp: 0 in the first RUN cycle, +1 per RUN cycle, wraps modulo 2^TS_W. Frozen outside RUN.
- Per module i, in RUN only:
  - Each cycle with mod_ready[i]=1 is one READY event.
  - Each cycle with mod_done[i]=1 is one DONE event.
  - ready_cnt[i] += mod_ready[i].
  - busy_cnt[i] += mod_start[i].
  - Both counters saturate at 2^TS_W-1.
- Pending latches: one {valid, kind, ts} per module.
  - A module's event is captured into its latch if the latch is empty, or is being written to the FIFO in that same cycle.
  - Otherwise the event is dropped and drop_count increments by 1.
  - If ready and done occur in the same cycle: READY is captured, DONE is dropped (+1).
  - Counters count all events, including dropped ones.
- Arbiter: round-robin over the latches. At most one FIFO write per cycle, only when the FIFO is not full. The pointer advances past the granted module.
- FLUSH: no capture; latches drain through the arbiter.
- SUMMARY:
  - For mod_id 0..N_MOD-1 in order, writes kind 2 then kind 3.
  - 2*N_MOD writes total, one per cycle while the FIFO is not full.
- FIFO: first-word-fall-through. rec_valid = !empty. A pop happens on rec_valid && rec_ready. A simultaneous push and pop when full is not allowed (push stalls).

## Timing
- Reset values: rec_valid=0, rec_data=0, drop_count=0, done=0, state IDLE.
  - Reset also clears all counters, latches, FIFO pointers, timestamp and arbiter pointer.
  - Reset mid-operation discards all buffered records immediately.
- enable sampled high at edge k: RUN from cycle k+1, timestamp=0 in that cycle.
- Event in RUN cycle t with ts=T:
  - Latch is set at the end of t.
  - Earliest FIFO write is at the end of t+1.
  - rec_valid=1 with payload T in cycle t+2 (empty FIFO, no contention).
- finish=1 in cycle t: events in cycle t are still captured; state is FLUSH from t+1.
- rec_ready low: the FIFO fills, latches hold, and further events on held modules drop. Counters are unaffected.
- done rises the cycle after the last record is popped and stays high.

## Test plan
- Single event: enable at 0, mod_ready[3] pulses in RUN cycle 5. Required: record {0,3,5} on rec_valid 2 cycles later, drop_count=0.
- Contention: mod_ready[0..9] all high for one cycle at ts=7. Required: 10 kind-0 records, ts=7, mod_id order 0..9 (pointer at 0 after reset), no drops.
- Overflow/backpressure: rec_ready=0, mod_ready[2] high for 40 cycles. Required: FIFO holds 16 records, latch 1 event, drop_count=23, ready_cnt[2]=40 in summary.
- Simultaneous ready+done on module 1 with an empty latch: READY record emitted, drop_count=1.
- finish after 100 RUN cycles with mod_start[4] high for 30 of them. Required: after event drain, 20 summary records, {3,4,30} present, done=1 after the last pop.
- Assert ap_rst_n low mid-SUMMARY. Required: rec_valid=0, drop_count=0, done=0 immediately; re-enable restarts with timestamp 0.
